// File: rtl/ts_cc_error_monitor_if.sv
// ts_cc_error_monitor_if: byte-stream inputs and error status outputs of the TS CC monitor
interface ts_cc_error_monitor_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]       valid;
  logic [N_CH-1:0]       sync;
  logic [8*N_CH-1:0]     data;
  logic                  clear_count;
  logic [CNT_W*N_CH-1:0] error_count;
  logic [N_CH-1:0]       error_pulse;
  logic [N_CH-1:0]       locked;
  modport master (
    output valid, sync, data, clear_count,
    input  error_count, error_pulse, locked
  );
  modport slave (
    input  valid, sync, data, clear_count,
    output error_count, error_pulse, locked
  );
endinterface

// File: rtl/ts_cc_error_monitor.sv
// ts_cc_error_monitor: per-channel MPEG-2 TS continuity-counter checker with error counters
module ts_cc_error_monitor #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input logic clk,
  input logic reset,
  ts_cc_error_monitor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, H1, H2, H3} state_t;
  logic [CNT_W-1:0] cnt [N_CH];
  logic             pulse [N_CH];
  logic             lck [N_CH];
  always_comb begin
    bus.error_count = '0;
    bus.error_pulse = '0;
    bus.locked      = '0;
    for (int k = 0; k < N_CH; k++) begin
      bus.error_count[CNT_W*k +: CNT_W] = cnt[k];
      bus.error_pulse[k]                = pulse[k];
      bus.locked[k]                     = lck[k];
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t      st, nxt;
    logic [7:0]  d;
    logic        v, s, tei, dup, hdr, eval, skip, relock, seq, same, err;
    logic [4:0]  pid_hi;
    logic [7:0]  pid_lo;
    logic [12:0] pid, ref_pid;
    logic [3:0]  last;
    assign d   = bus.data[8*i +: 8];
    assign v   = bus.valid[i];
    assign s   = bus.sync[i];
    assign pid = {pid_hi, pid_lo};
    // A sync byte always restarts header parsing, even mid-header
    always_comb begin
      hdr    = v & ~s;
      nxt    = !v ? st : s ? (d == 8'h47 ? H1 : IDLE) : st == H1 ? H2 : st == H2 ? H3 : IDLE;
      eval   = hdr & (st == H3);
      skip   = tei | (&pid) | (d[5:4] == 2'b00);
      relock = ~lck[i] | (pid != ref_pid);
      seq    = d[3:0] == last + 4'd1;
      same   = d[3:0] == last;
      err    = eval & ~skip & ~relock & (d[4] ? ~(seq | (same & ~dup)) : ~same);
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        st       <= IDLE;
        tei      <= 1'b0;
        pid_hi   <= '0;
        pid_lo   <= '0;
        ref_pid  <= '0;
        last     <= '0;
        dup      <= 1'b0;
        lck[i]   <= 1'b0;
        pulse[i] <= 1'b0;
        cnt[i]   <= '0;
      end else begin
        st       <= nxt;
        pulse[i] <= err;
        if (hdr && st == H1) {tei, pid_hi} <= {d[7], d[4:0]};
        if (hdr && st == H2) pid_lo <= d;
        // last CC always follows the evaluated packet; only the dup flag needs care
        if (eval && !skip) begin
          ref_pid <= pid;
          last    <= d[3:0];
          lck[i]  <= 1'b1;
          dup     <= relock ? 1'b0 : d[4] ? same & ~dup : dup;
        end
        cnt[i] <= bus.clear_count ? '0 : !err ? cnt[i] :
                  (SATURATE && &cnt[i]) ? cnt[i] : cnt[i] + 1'b1;
      end
  end
endmodule

// File: tb/tb_ts_cc_error_monitor.sv
// tb_ts_cc_error_monitor: packet-level reference model checks of three monitor configurations
module tb_ts_cc_error_monitor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ts_cc_error_monitor_if #(.N_CH(4), .CNT_W(8)) b8();
  ts_cc_error_monitor_if #(.N_CH(4), .CNT_W(4)) b4s();
  ts_cc_error_monitor_if #(.N_CH(4), .CNT_W(4)) b4w();
  assign b4s.valid = b8.valid;
  assign b4s.sync = b8.sync;
  assign b4s.data = b8.data;
  assign b4s.clear_count = b8.clear_count;
  assign b4w.valid = b8.valid;
  assign b4w.sync = b8.sync;
  assign b4w.data = b8.data;
  assign b4w.clear_count = b8.clear_count;

  ts_cc_error_monitor #(.N_CH(4), .CNT_W(8), .SATURATE(1'b1)) u8 (.clk(clk), .reset(reset), .bus(b8));
  ts_cc_error_monitor #(.N_CH(4), .CNT_W(4), .SATURATE(1'b1)) u4s (.clk(clk), .reset(reset), .bus(b4s));
  ts_cc_error_monitor #(.N_CH(4), .CNT_W(4), .SATURATE(1'b0)) u4w (.clk(clk), .reset(reset), .bus(b4w));

  int n_cmp = 0;
  int n_fail = 0;
  logic        m_lck [4];
  logic        m_dup [4];
  logic [12:0] m_pid [4];
  logic [3:0]  m_cc [4];
  int          m_n [4];
  logic        f_tei [4];
  logic [12:0] f_pid [4];
  logic [1:0]  f_afc [4];
  logic [3:0]  f_cc [4];
  logic [3:0]  exp_p, obs_p;

  function automatic logic [63:0] exp_cnt();
    logic [63:0] r;
    for (int c = 0; c < 4; c++) begin
      r[8*c +: 8]       = 8'(m_n[c] > 255 ? 255 : m_n[c]);
      r[32 + 4*c +: 4]  = 4'(m_n[c] > 15 ? 15 : m_n[c]);
      r[48 + 4*c +: 4]  = 4'(m_n[c] % 16);
    end
    return r;
  endfunction

  function automatic logic [63:0] obs_cnt();
    return {b4w.error_count, b4s.error_count, b8.error_count};
  endfunction

  function automatic logic [3:0] exp_lck();
    return {m_lck[3], m_lck[2], m_lck[1], m_lck[0]};
  endfunction

  task automatic reset_model();
    for (int c = 0; c < 4; c++) begin
      m_lck[c] = 0; m_dup[c] = 0; m_pid[c] = '0; m_cc[c] = '0; m_n[c] = 0;
    end
  endtask

  // Continuity rules applied to one whole packet per selected channel
  task automatic model_update(input logic [3:0] m, input bit clr);
    exp_p = '0;
    if (clr) for (int c = 0; c < 4; c++) m_n[c] = 0;
    for (int c = 0; c < 4; c++)
      if (m[c] && !(f_tei[c] || f_pid[c] == 13'h1FFF || f_afc[c] == 2'b00)) begin
        bit e;
        e = 0;
        if (!m_lck[c] || f_pid[c] != m_pid[c]) begin
          m_lck[c] = 1; m_pid[c] = f_pid[c]; m_dup[c] = 0;
        end else if (f_afc[c] == 2'b10) e = f_cc[c] != m_cc[c];
        else if (f_cc[c] == 4'(m_cc[c] + 1)) m_dup[c] = 0;
        else if (f_cc[c] == m_cc[c] && !m_dup[c]) m_dup[c] = 1;
        else begin e = 1; m_dup[c] = 0; end
        m_cc[c] = f_cc[c];
        exp_p[c] = e;
        if (!clr && e) m_n[c]++;
      end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] vm;
    for (int c = 0; c < 4; c++) vm[8*c +: 8] = {8{v[c]}};
    b8.valid = v;
    b8.sync = (s & v) | (4'($urandom) & ~v);
    b8.data = (d & vm) | ($urandom & ~vm);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] m, input bit clr, input bit stalls);
    logic [31:0] d [4];
    for (int c = 0; c < 4; c++) begin
      d[0][8*c +: 8] = 8'h47;
      d[1][8*c +: 8] = {f_tei[c], 2'($urandom), f_pid[c][12:8]};
      d[2][8*c +: 8] = f_pid[c][7:0];
      d[3][8*c +: 8] = {2'($urandom), f_afc[c], f_cc[c]};
    end
    for (int k = 0; k < 4; k++) begin
      if (stalls) repeat ($urandom_range(2)) drive(4'h0, 4'h0, 32'h0);
      b8.clear_count = clr && k == 3;
      drive(m, k == 0 ? m : 4'h0, d[k]);
    end
    obs_p = b8.error_pulse;
    b8.clear_count = 1'b0;
    model_update(m, clr);
    repeat ($urandom_range(2)) drive(m, 4'h0, $urandom);
  endtask

  task automatic set_f(input int c, input logic tei, input logic [12:0] pid, input logic [1:0] afc, input logic [3:0] cc);
    f_tei[c] = tei; f_pid[c] = pid; f_afc[c] = afc; f_cc[c] = cc;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (obs_cnt() !== 64'h0) begin n_fail++; $display("FAIL reset count: got %h want 0", obs_cnt()); end
    n_cmp++; if (b8.error_pulse !== 4'h0 || b4w.error_pulse !== 4'h0) begin n_fail++; $display("FAIL reset pulse: got %b want 0000", b8.error_pulse); end
    n_cmp++; if (b8.locked !== 4'h0 || b4s.locked !== 4'h0) begin n_fail++; $display("FAIL reset locked: got %b want 0000", b8.locked); end
    reset = 1'b0;
  endtask

  task automatic test_ch0_lock();
    for (int i = 0; i < 17; i++) begin
      set_f(0, 0, 13'h100, 2'b01, 4'(i));
      send(4'b0001, 0, 1);
      n_cmp++; if (obs_p !== exp_p) begin n_fail++; $display("FAIL lock pulse pkt%0d: got %b want %b", i, obs_p, exp_p); end
      n_cmp++; if (obs_cnt() !== exp_cnt()) begin n_fail++; $display("FAIL lock count pkt%0d: got %h want %h", i, obs_cnt(), exp_cnt()); end
    end
    n_cmp++; if (b8.locked[0] !== 1'b1 || b8.error_count[7:0] !== 8'd0) begin n_fail++; $display("FAIL lock final: locked %b count %0d want 1 0", b8.locked[0], b8.error_count[7:0]); end
  endtask

  task automatic test_cc_gap();
    logic [3:0] ccs [4] = '{4'd3, 4'd4, 4'd6, 4'd7};
    for (int k = 0; k < 4; k++) begin
      set_f(1, 0, 13'h101, 2'b01, ccs[k]);
      send(4'b0010, 0, 1);
      n_cmp++; if (obs_p !== exp_p) begin n_fail++; $display("FAIL gap pulse pkt%0d: got %b want %b", k, obs_p, exp_p); end
      n_cmp++; if (obs_p !== (k == 2 ? 4'b0010 : 4'b0000)) begin n_fail++; $display("FAIL gap pulse const pkt%0d: got %b", k, obs_p); end
      n_cmp++; if (obs_cnt() !== exp_cnt()) begin n_fail++; $display("FAIL gap count pkt%0d: got %h want %h", k, obs_cnt(), exp_cnt()); end
    end
    n_cmp++; if (b8.error_count[15:8] !== 8'd1) begin n_fail++; $display("FAIL gap final count: got %0d want 1", b8.error_count[15:8]); end
  endtask

  task automatic test_dup();
    logic [1:0] afcs [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    for (int k = 0; k < 4; k++) begin
      set_f(2, 0, 13'h102, afcs[k], 4'd5);
      send(4'b0100, 0, 1);
      n_cmp++; if (obs_p !== exp_p) begin n_fail++; $display("FAIL dup pulse pkt%0d: got %b want %b", k, obs_p, exp_p); end
      n_cmp++; if (obs_p[2] !== (k == 2)) begin n_fail++; $display("FAIL dup pulse const pkt%0d: got %b", k, obs_p[2]); end
    end
    n_cmp++; if (b8.error_count[23:16] !== 8'd1 || obs_cnt() !== exp_cnt()) begin n_fail++; $display("FAIL dup count: got %h want %h", obs_cnt(), exp_cnt()); end
  endtask

  task automatic test_skip();
    logic        teis [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [12:0] pids [6] = '{13'h200, 13'h200, 13'h1FFF, 13'h200, 13'h300, 13'h300};
    logic [1:0]  afcs [6] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11};
    logic [3:0]  ccs [6]  = '{4'd0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd10};
    for (int k = 0; k < 6; k++) begin
      set_f(3, teis[k], pids[k], afcs[k], ccs[k]);
      send(4'b1000, 0, 1);
      n_cmp++; if (obs_p !== 4'b0000 || obs_p !== exp_p) begin n_fail++; $display("FAIL skip pulse pkt%0d: got %b want 0000", k, obs_p); end
      n_cmp++; if (b8.locked !== exp_lck()) begin n_fail++; $display("FAIL skip locked pkt%0d: got %b want %b", k, b8.locked, exp_lck()); end
    end
    n_cmp++; if (b8.error_count[31:24] !== 8'd0 || obs_cnt() !== exp_cnt()) begin n_fail++; $display("FAIL skip count: got %h want %h", obs_cnt(), exp_cnt()); end
  endtask

  task automatic test_all_channels();
    for (int c = 0; c < 4; c++) set_f(c, 0, m_pid[c], 2'b01, 4'(m_cc[c] + 3));
    send(4'hF, 0, 1);
    n_cmp++; if (obs_p !== 4'hF || obs_p !== exp_p) begin n_fail++; $display("FAIL all pulse: got %b want 1111", obs_p); end
    n_cmp++; if (obs_cnt() !== exp_cnt()) begin n_fail++; $display("FAIL all count: got %h want %h", obs_cnt(), exp_cnt()); end
  endtask

  task automatic test_clear_collision();
    set_f(0, 0, m_pid[0], 2'b01, 4'(m_cc[0] + 2));
    send(4'b0001, 1, 0);
    n_cmp++; if (obs_p[0] !== 1'b1 || obs_p !== exp_p) begin n_fail++; $display("FAIL clear pulse: got %b want %b", obs_p, exp_p); end
    n_cmp++; if (obs_cnt() !== 64'h0) begin n_fail++; $display("FAIL clear count: got %h want 0", obs_cnt()); end
    n_cmp++; if (b8.locked !== exp_lck()) begin n_fail++; $display("FAIL clear locked: got %b want %b", b8.locked, exp_lck()); end
  endtask

  task automatic test_abort();
    logic [3:0] bad;
    bad = 4'(m_cc[0] + 5);
    drive(4'b0001, 4'b0001, 32'h47);
    drive(4'b0001, 4'b0000, 32'h01);
    drive(4'b0001, 4'b0000, 32'h00);
    drive(4'b0001, 4'b0001, 32'h00);
    drive(4'b0001, 4'b0000, {24'h0, 4'b0001, bad});
    drive(4'b0000, 4'b0000, 32'h0);
    n_cmp++; if (b8.error_pulse !== 4'h0 || obs_cnt() !== exp_cnt()) begin n_fail++; $display("FAIL abort ignored: pulse %b count %h want 0000 %h", b8.error_pulse, obs_cnt(), exp_cnt()); end
    drive(4'b0001, 4'b0001, 32'h47);
    drive(4'b0001, 4'b0000, 32'h01);
    drive(4'b0001, 4'b0001, 32'h47);
    drive(4'b0001, 4'b0000, 32'h01);
    drive(4'b0001, 4'b0000, 32'h00);
    drive(4'b0001, 4'b0000, {24'h0, 4'b0001, bad});
    obs_p = b8.error_pulse;
    set_f(0, 0, 13'h100, 2'b01, bad);
    model_update(4'b0001, 0);
    n_cmp++; if (obs_p !== exp_p) begin n_fail++; $display("FAIL abort restart pulse: got %b want %b", obs_p, exp_p); end
    n_cmp++; if (obs_cnt() !== exp_cnt()) begin n_fail++; $display("FAIL abort restart count: got %h want %h", obs_cnt(), exp_cnt()); end
  endtask

  task automatic test_saturation();
    b8.clear_count = 1'b1;
    drive(4'h0, 4'h0, 32'h0);
    b8.clear_count = 1'b0;
    for (int c = 0; c < 4; c++) m_n[c] = 0;
    for (int i = 0; i < 20; i++) begin
      set_f(0, 0, m_pid[0], 2'b01, 4'(m_cc[0] + 2));
      send(4'b0001, 0, 1'($urandom_range(1)));
      n_cmp++; if (obs_p !== exp_p) begin n_fail++; $display("FAIL sat pulse pkt%0d: got %b want %b", i, obs_p, exp_p); end
      n_cmp++; if (obs_cnt() !== exp_cnt()) begin n_fail++; $display("FAIL sat count pkt%0d: got %h want %h", i, obs_cnt(), exp_cnt()); end
    end
    n_cmp++; if (b4s.error_count[3:0] !== 4'd15) begin n_fail++; $display("FAIL sat hold: got %0d want 15", b4s.error_count[3:0]); end
    n_cmp++; if (b4w.error_count[3:0] !== 4'd4) begin n_fail++; $display("FAIL sat wrap: got %0d want 4", b4w.error_count[3:0]); end
    n_cmp++; if (b8.error_count[7:0] !== 8'd20) begin n_fail++; $display("FAIL sat wide: got %0d want 20", b8.error_count[7:0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) begin
        int r;
        r = $urandom_range(9);
        f_tei[c] = $urandom_range(19) == 0;
        f_pid[c] = $urandom_range(19) == 0 ? 13'h1FFF : $urandom_range(14) == 0 ? 13'h0A0 + 13'(c) : 13'h100 + 13'(c);
        f_afc[c] = $urandom_range(19) == 0 ? 2'b00 : 2'($urandom_range(1, 3));
        f_cc[c] = r < 6 ? 4'(m_cc[c] + 1) : r < 8 ? m_cc[c] : 4'($urandom_range(15));
      end
      send(m, $urandom_range(29) == 0, 1);
      n_cmp++; if (obs_p !== exp_p) begin n_fail++; $display("FAIL rand pulse it%0d: got %b want %b", i, obs_p, exp_p); end
      n_cmp++; if (obs_cnt() !== exp_cnt()) begin n_fail++; $display("FAIL rand count it%0d: got %h want %h", i, obs_cnt(), exp_cnt()); end
      n_cmp++; if (b8.locked !== exp_lck()) begin n_fail++; $display("FAIL rand locked it%0d: got %b want %b", i, b8.locked, exp_lck()); end
    end
  endtask

  task automatic test_reset_mid_header();
    for (int c = 0; c < 4; c++) set_f(c, 0, 13'h100 + 13'(c), 2'b01, 4'(m_cc[c] + 7));
    send(4'hF, 0, 0);
    drive(4'hF, 4'hF, 32'h47474747);
    drive(4'hF, 4'h0, 32'h01010101);
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (obs_cnt() !== 64'h0) begin n_fail++; $display("FAIL midreset count: got %h want 0", obs_cnt()); end
    n_cmp++; if (b8.locked !== 4'h0 || b8.error_pulse !== 4'h0) begin n_fail++; $display("FAIL midreset flags: locked %b pulse %b want 0000", b8.locked, b8.error_pulse); end
    @(posedge clk); #1;
    reset = 1'b0;
    reset_model();
    drive(4'hF, 4'h0, 32'h00000000);
    set_f(0, 0, 13'h100, 2'b01, 4'd9);
    send(4'b0001, 0, 0);
    n_cmp++; if (obs_p !== exp_p || b8.locked !== exp_lck()) begin n_fail++; $display("FAIL post-reset relock: pulse %b locked %b want %b %b", obs_p, b8.locked, exp_p, exp_lck()); end
  endtask

  initial begin
    b8.valid = '0;
    b8.sync = '0;
    b8.data = '0;
    b8.clear_count = 1'b0;
    reset_model();
    test_reset();
    test_ch0_lock();
    test_cc_gap();
    test_dup();
    test_skip();
    test_all_channels();
    test_clear_collision();
    test_abort();
    test_saturation();
    test_random();
    test_reset_mid_header();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
